// File: rtl/sram_port_arbiter.sv
// Arbiter sharing one single-port synchronous SRAM between the fetch port
// and the data-memory port. The data port normally wins a conflict; a
// starvation counter lets fetch win once it has been denied STARVE_LIMIT
// cycles in a row. Responses come back exactly one cycle after grant.
module sram_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic        if_addr_ok,
  output logic        if_data_ok,
  output logic [31:0] if_rdata,
  // data port
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [3:0]  dm_wstrb,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_addr_ok,
  output logic        dm_data_ok,
  output logic [31:0] dm_rdata,
  // SRAM side
  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             grant_if;
  logic             grant_dm;
  logic             resp_valid_reg;
  logic             resp_owner_reg;   // 0 = fetch, 1 = data
  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;

  // Pick at most one winner this cycle; nothing is granted while in reset.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (resetn) begin
      if (dm_req && if_req) begin
        if (starve_cnt_reg == LIMIT) grant_if = 1'b1;
        else                         grant_dm = 1'b1;
      end else if (dm_req) begin
        grant_dm = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  assign if_addr_ok = grant_if;
  assign dm_addr_ok = grant_dm;

  // SRAM request comes straight from the winner; zeros when idle.
  assign ram_en    = grant_if | grant_dm;
  assign ram_addr  = grant_dm ? dm_addr  : (grant_if ? if_addr : 32'd0);
  assign ram_wdata = grant_dm ? dm_wdata : 32'd0;

  // Byte-lane write enables: only a granted data write drives them.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_we_lane
      assign ram_we[gi] = grant_dm & dm_wr & dm_wstrb[gi];
    end
  endgenerate

  // Count consecutive denied fetch cycles, saturating at the limit.
  always_comb begin
    starve_cnt_next = '0;
    if (if_req && !grant_if) begin
      if (starve_cnt_reg == LIMIT) starve_cnt_next = starve_cnt_reg;
      else                         starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
  end

  // Response tracking and starvation state; reset drops any in-flight reply.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_valid_reg <= 1'b0;
      resp_owner_reg <= 1'b0;
      starve_cnt_reg <= '0;
    end else begin
      resp_valid_reg <= grant_if | grant_dm;
      resp_owner_reg <= grant_dm;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // A redirect squashes only the fetch reply landing in the same cycle.
  assign if_data_ok = resetn & resp_valid_reg & ~resp_owner_reg & ~if_cancel;
  assign dm_data_ok = resetn & resp_valid_reg &  resp_owner_reg;

  // Read data is shared; the data_ok strobes say who it belongs to.
  assign if_rdata = ram_rdata;
  assign dm_rdata = ram_rdata;

endmodule
